// File: rtl/serial_nibble_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_nibble_adder_ctrl
//
// Performs one WIDTH-bit addition (a + b + c_in) over NIBBLES = WIDTH/4 clock
// cycles using a single 4-bit ripple slice. Nibble 0 is processed first and the
// carry between nibbles is kept in a register, so the carry reaches nibble k+1
// only on the following clock, never combinationally.
//
// Optional feature macro: ADD_OVF_FLAG_EN
//   defined   -> the ovf port exists and reports two's-complement overflow.
//   undefined -> no ovf port and no overflow logic; all else identical.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      request present on a/b/c_in
//   in_ready   out  1      block can accept a request (IDLE)
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   c_in       in   1      carry into nibble 0
//   out_valid  out  1      sum/c_out(/ovf) valid (DONE)
//   out_ready  in   1      consumer takes the result
//   sum        out  WIDTH  low WIDTH bits of a + b + c_in
//   c_out      out  1      carry out of the top nibble
//   ovf        out  1      signed overflow (only with ADD_OVF_FLAG_EN)
//   state_dbg  out  2      current FSM state (0=IDLE, 1=RUN, 2=DONE)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1 and rst is 0. in_ready is high only in IDLE and out_valid only in
// DONE, so the two are never high together; after the result handoff the next
// request can be accepted one cycle later at the earliest.
// -----------------------------------------------------------------------------
module serial_nibble_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
`ifdef ADD_OVF_FLAG_EN
  output logic             ovf,
`endif
  output logic [1:0]       state_dbg
);

  localparam int NIBBLES = WIDTH / 4;
  // Keep the counter at least one bit wide so WIDTH=4 still elaborates.
  localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

  if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_bad_width
    $error("serial_nibble_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic             c_out_q;
`ifdef ADD_OVF_FLAG_EN
  logic             ovf_q;
`endif

  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [4:0]       slice;
  logic             last_nib;
  logic             accept;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid)  state_d = RUN;
      RUN:  if (last_nib)  state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default:             state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs decoded from state only
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  assign state_dbg = state_q;

  // ---------------------------------------------------------------------------
  // Datapath: one 4-bit slice, fed from the latched operands by nibble index
  // ---------------------------------------------------------------------------
  assign accept   = (state_q == IDLE) && in_valid;
  assign last_nib = (cnt_q == LAST_NIB);
  assign a_nib    = a_q[4*cnt_q +: 4];
  assign b_nib    = b_q[4*cnt_q +: 4];
  assign slice    = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
`ifdef ADD_OVF_FLAG_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= c_in;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          // Only the current nibble of sum is written; the others keep
          // whatever they held until their turn comes.
          sum_q[4*cnt_q +: 4] <= slice[3:0];
          carry_q             <= slice[4];
          if (last_nib) begin
            cnt_q   <= '0;
            c_out_q <= slice[4];
`ifdef ADD_OVF_FLAG_EN
            // Same-sign operands whose result sign differs -> overflow.
            ovf_q   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                       (slice[3] != a_q[WIDTH-1]);
`endif
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          // DONE: everything holds until the consumer takes the result.
        end
      endcase
    end
  end

  assign sum   = sum_q;
  assign c_out = c_out_q;
`ifdef ADD_OVF_FLAG_EN
  assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_nibble_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_nibble_adder_ctrl
//
// Directed cases plus 20 randomized operations with random gaps and random
// out_ready. A monitor on the falling edge records accepted requests into an
// expected queue (computed with plain integer arithmetic) and compares every
// DONE cycle and every result handoff against the queue head.
// -----------------------------------------------------------------------------
module tb_serial_nibble_adder_ctrl;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;
  logic [1:0]   state_dbg;
  logic         ovf_obs;

`ifdef ADD_OVF_FLAG_EN
  logic         ovf;
  assign ovf_obs = ovf;
`else
  assign ovf_obs = 1'b0;
`endif

  always #5 clk = ~clk;

  serial_nibble_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
`ifdef ADD_OVF_FLAG_EN
    .ovf       (ovf),
`endif
    .state_dbg (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int           n_tests = 0;
  int           n_fail  = 0;
  int           cyc     = 0;
  int           rx_cnt  = 0;
  int           acc_edge = 0;
  logic         prev_ov = 1'b0;
  logic [W+1:0] exp_q[$];
  logic [W+1:0] head;
  logic [W-1:0] last_sum;
  logic         last_c;
  logic         last_ovf;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {ovf, c_out, sum} from whole-number arithmetic.
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] x,
                                           input logic [W-1:0] y,
                                           input logic ci);
    longint ux, uy, tot, sx, sy, st;
    logic   ov;
    ux  = longint'(x);
    uy  = longint'(y);
    tot = ux + uy + longint'(ci);
    sx  = x[W-1] ? ux - (longint'(1) << W) : ux;
    sy  = y[W-1] ? uy - (longint'(1) << W) : uy;
    st  = sx + sy + longint'(ci);
    ov  = (st > ((longint'(1) << (W-1)) - 1)) || (st < -(longint'(1) << (W-1)));
`ifndef ADD_OVF_FLAG_EN
    ov  = 1'b0;
`endif
    return {ov, tot[W], tot[W-1:0]};
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard / monitor (inputs change at posedge+1, so negedge is stable)
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_ov = 1'b0;
    end else begin
      if (out_valid) begin
        check("done_in_ready_low", in_ready, 1'b0);
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", 1'b1, 1'b0);
        end else begin
          head = exp_q[0];
          check("sum", sum, head[W-1:0]);
          check("c_out", c_out, head[W]);
          check("ovf", ovf_obs, head[W+1]);
          if (!prev_ov) check("latency", cyc - acc_edge, NIB);
          if (out_ready) begin
            last_sum = sum;
            last_c   = c_out;
            last_ovf = ovf_obs;
            void'(exp_q.pop_front());
            rx_cnt++;
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_add(a, b, c_in));
        acc_edge = cyc + 1;
      end
      prev_ov = out_valid;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (called just after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    bit   done;
    logic rdy;
    done     = 1'b0;
    a        = x;
    b        = y;
    c_in     = ci;
    in_valid = 1'b1;
    for (int i = 0; i < 64 && !done; i++) begin
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy && !rst) done = 1'b1;
    end
    in_valid = 1'b0;
    if (!done) check("accept_timeout", 1'b0, 1'b1);
  endtask

  task automatic wait_result();
    int start;
    start = rx_cnt;
    for (int i = 0; i < 64 && rx_cnt == start; i++) begin
      @(posedge clk);
      #1;
    end
    if (rx_cnt == start) check("result_timeout", 1'b0, 1'b1);
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    send(x, y, ci);
    wait_result();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int start;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    c_in      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check("reset_in_ready", in_ready, 1'b1);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_sum", sum, 16'h0000);
    check("reset_c_out", c_out, 1'b0);
    check("reset_ovf", ovf_obs, 1'b0);

    // Basic and carry ripple
    run_op(16'h1234, 16'h4321, 1'b0);
    check("basic_sum", last_sum, 16'h5555);
    check("basic_c", last_c, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0);
    check("ripple1_sum", last_sum, 16'h0000);
    check("ripple1_c", last_c, 1'b1);
    run_op(16'hFFFF, 16'h0000, 1'b1);
    check("ripple2_sum", last_sum, 16'h0000);
    check("ripple2_c", last_c, 1'b1);

`ifdef ADD_OVF_FLAG_EN
    run_op(16'h7FFF, 16'h0001, 1'b0);
    check("ovf1_sum", last_sum, 16'h8000);
    check("ovf1_ovf", last_ovf, 1'b1);
    check("ovf1_c", last_c, 1'b0);
    run_op(16'h8000, 16'h8000, 1'b0);
    check("ovf2_sum", last_sum, 16'h0000);
    check("ovf2_ovf", last_ovf, 1'b1);
    check("ovf2_c", last_c, 1'b1);
`endif

    // Backpressure with in_valid noise during RUN and DONE
    out_ready = 1'b0;
    send(16'hABCD, 16'h1111, 1'b1);
    in_valid = 1'b1;
    for (int i = 0; i < 32 && !out_valid; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      @(posedge clk);
      #1;
    end
    check("bp_reached_done", out_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_sum_hold", sum, 16'hBCDF);
      check("bp_c_hold", c_out, 1'b0);
      a = W'($urandom);
      in_valid = ~in_valid;
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_result();
    check("bp_sum", last_sum, 16'hBCDF);
    check("bp_idle_ready", in_ready, 1'b1);

    // Reset on the second RUN cycle
    send(16'h5555, 16'h5555, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_mid_in_ready", in_ready, 1'b1);
    check("rst_mid_out_valid", out_valid, 1'b0);
    check("rst_mid_sum", sum, 16'h0000);
    run_op(16'h0F0F, 16'h00F1, 1'b0);
    check("after_rst_sum", last_sum, 16'h1000);
    check("after_rst_c", last_c, 1'b0);

    // Back-to-back random operations
    start = rx_cnt;
    fork
      begin
        for (int n = 0; n < 20; n++) begin
          repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
          end
          send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
        end
      end
      begin
        for (int i = 0; i < 3000 && (rx_cnt - start) < 20; i++) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
      end
    join
    out_ready = 1'b1;
    check("rand_count", rx_cnt - start, 20);
    check("rand_queue_empty", exp_q.size(), 0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
